// File: rtl/core_mc_pkg.sv
// Shared types and constants for the multi-cycle core: FSM states, opcode fields,
// ALU select encoding and the immediate-format decode helper.
package core_mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALT
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_sel_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_ECALL
    } inst_cls_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        inst_cls_e   cls;
        alu_sel_e    alu_sel;
        logic        use_imm;
        logic        br_ne;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctrl_t;

    // B/J immediates come out as byte offsets with bit 0 already zero.
    function automatic logic [31:0] imm_decode(input logic [31:0] ir, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/core_mc_decode.sv
// Combinational instruction decode: IR to control bundle (class, ALU select,
// immediate, register fields, illegal flag).
module core_mc_decode
    import core_mc_pkg::*;
(
    input  logic [31:0] ir_i,
    output ctrl_t       ctrl_o
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    imm_fmt_e   fmt;

    assign opcode = ir_i[6:0];
    assign funct3 = ir_i[14:12];
    assign funct7 = ir_i[31:25];

    always_comb begin
        ctrl_o         = '0;
        ctrl_o.cls     = CLS_ALU;
        ctrl_o.alu_sel = ALU_ADD;
        ctrl_o.rd      = ir_i[11:7];
        ctrl_o.rs1     = ir_i[19:15];
        ctrl_o.rs2     = ir_i[24:20];
        fmt            = IMM_NONE;

        case (opcode)
            OP_R: begin
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD_SUB}: ctrl_o.alu_sel = ALU_ADD;
                    {F7_SUB,  F3_ADD_SUB}: ctrl_o.alu_sel = ALU_SUB;
                    {F7_BASE, F3_AND}:     ctrl_o.alu_sel = ALU_AND;
                    {F7_BASE, F3_OR}:      ctrl_o.alu_sel = ALU_OR;
                    {F7_BASE, F3_SLT}:     ctrl_o.alu_sel = ALU_SLT;
                    default:               ctrl_o.illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                ctrl_o.use_imm = 1'b1;
                fmt            = IMM_I;
                if (funct3 != F3_ADD_SUB) ctrl_o.illegal = 1'b1;
            end
            OP_LOAD: begin
                ctrl_o.cls     = CLS_LOAD;
                ctrl_o.use_imm = 1'b1;
                fmt            = IMM_I;
                if (funct3 != F3_WORD) ctrl_o.illegal = 1'b1;
            end
            OP_STORE: begin
                ctrl_o.cls     = CLS_STORE;
                ctrl_o.use_imm = 1'b1;
                fmt            = IMM_S;
                if (funct3 != F3_WORD) ctrl_o.illegal = 1'b1;
            end
            OP_BRANCH: begin
                // Branch compares via rs1 - rs2 and the ALU zero flag.
                ctrl_o.cls     = CLS_BRANCH;
                ctrl_o.alu_sel = ALU_SUB;
                ctrl_o.br_ne   = (funct3 == F3_BNE);
                fmt            = IMM_B;
                if ((funct3 != F3_BEQ) && (funct3 != F3_BNE)) ctrl_o.illegal = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.cls = CLS_JAL;
                fmt        = IMM_J;
            end
            OP_SYSTEM: ctrl_o.cls = CLS_ECALL;
            default:   ctrl_o.illegal = 1'b1;
        endcase

        ctrl_o.imm = imm_decode(ir_i, fmt);
    end
endmodule

// File: rtl/register_file.sv
// 32 x 32-bit integer register file, two async read ports, one write port.
// x0 always reads as zero and ignores writes.
module register_file (
    input  logic        clock,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] regs_q [0:31];
    logic [31:0] regs_d [0:31];

    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != 5'd0)) regs_d[waddr_i] = wdata_i;
    end

    always_ff @(posedge clock) begin
        regs_q <= regs_d;
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];
endmodule

// File: rtl/ula.sv
// Integer ALU: 32-bit wrapping add/sub, bitwise and/or, signed set-less-than.
module ula
    import core_mc_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_sel_e    sel_i,
    output logic [31:0] result_o,
    output logic        zero_o
);
    always_comb begin
        result_o = 32'd0;
        case (sel_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            default: result_o = 32'd0;
        endcase
    end

    assign zero_o = (result_o == 32'd0);
endmodule

// File: rtl/core_multicycle.sv
// Multi-cycle RV32I-subset core over one shared valid/ready memory port.
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT sequencing with trap and instret reporting.
module core_multicycle
    import core_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       pc_o,
    output logic              halted_o,
    output logic              trap_o,
    output logic [31:0]       instret_o
);
    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       rs1_q, rs1_d;
    logic [31:0]       rs2_q, rs2_d;
    logic [31:0]       wb_q, wb_d;
    logic [31:0]       instret_q, instret_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              halted_q, halted_d;
    logic              trap_q, trap_d;

    ctrl_t       ctrl;
    logic        rf_we;
    logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;
    logic [31:0] alu_b, alu_res;
    logic        alu_zero;
    logic [31:0] pc_plus4, pc_target, next_pc;
    logic        retire, br_taken;

    core_mc_decode u_decode (
        .ir_i   (ir_q),
        .ctrl_o (ctrl)
    );

    // Writes are suppressed while reset is sampled so an aborted instruction leaves no trace.
    register_file u_rf (
        .clock    (clock),
        .we_i     (rf_we && !reset),
        .waddr_i  (ctrl.rd),
        .wdata_i  (rf_wdata),
        .raddr1_i (ctrl.rs1),
        .raddr2_i (ctrl.rs2),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    assign alu_b = ctrl.use_imm ? ctrl.imm : rs2_q;

    ula u_ula (
        .a_i      (rs1_q),
        .b_i      (alu_b),
        .sel_i    (ctrl.alu_sel),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_target = pc_q + ctrl.imm;
    assign br_taken  = ctrl.br_ne ? !alu_zero : alu_zero;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        wb_d      = wb_q;
        instret_d = instret_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        req_d     = req_q;
        we_d      = we_q;
        halted_d  = halted_q;
        trap_d    = trap_q;
        rf_we     = 1'b0;
        rf_wdata  = wb_q;
        retire    = 1'b0;
        next_pc   = pc_plus4;

        case (state_q)
            ST_FETCH: begin
                // req_q low here only right after reset: launch the first fetch.
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q[ADDR_W-1:0];
                end else if (mem_ready_i) begin
                    ir_d    = mem_rdata_i;
                    req_d   = 1'b0;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rs1_d = rf_rdata1;
                rs2_d = rf_rdata2;
                if (ctrl.illegal) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                    trap_d   = 1'b1;
                end else if (ctrl.cls == CLS_ECALL) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (ctrl.cls)
                    CLS_ALU: begin
                        wb_d    = alu_res;
                        state_d = ST_WRITEBACK;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        if (alu_res[1:0] != 2'b00) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                            trap_d   = 1'b1;
                        end else begin
                            req_d   = 1'b1;
                            we_d    = (ctrl.cls == CLS_STORE);
                            addr_d  = alu_res[ADDR_W-1:0];
                            wdata_d = rs2_q;
                            state_d = ST_MEM;
                        end
                    end
                    CLS_BRANCH: begin
                        next_pc = br_taken ? pc_target : pc_plus4;
                        retire  = 1'b1;
                    end
                    CLS_JAL: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_plus4;
                        next_pc  = pc_target;
                        retire   = 1'b1;
                    end
                    default: begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                        trap_d   = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ready_i) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        retire = 1'b1;
                    end else begin
                        wb_d    = mem_rdata_i;
                        state_d = ST_WRITEBACK;
                    end
                end
            end
            ST_WRITEBACK: begin
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            ST_HALT: req_d = 1'b0;
            default: state_d = ST_HALT;
        endcase

        // Retiring always chains straight into the next fetch request.
        if (retire) begin
            pc_d      = next_pc;
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
            req_d     = 1'b1;
            we_d      = 1'b0;
            addr_d    = next_pc[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            rs1_q     <= 32'd0;
            rs2_q     <= 32'd0;
            wb_q      <= 32'd0;
            instret_q <= 32'd0;
            wdata_q   <= 32'd0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            halted_q  <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            wb_q      <= wb_d;
            instret_q <= instret_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            we_q      <= we_d;
            halted_q  <= halted_d;
            trap_q    <= trap_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign pc_o        = pc_q;
    assign halted_o    = halted_q;
    assign trap_o      = trap_q;
    assign instret_o   = instret_q;
endmodule

// File: tb/tb_core_multicycle.sv
// Scoreboard bench for core_multicycle: directed programs, expected bus transfers
// queued up front and checked by an independent monitor at every handshake.
module tb_core_multicycle;

    logic        clock;
    logic        reset;
    logic        mem_req_o, mem_we_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [31:0] pc_o, instret_o;
    logic        halted_o, trap_o;

    core_multicycle #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i),
        .pc_o        (pc_o),
        .halted_o    (halted_o),
        .trap_o      (trap_o),
        .instret_o   (instret_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
    } txn_t;

    txn_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_hs = 0;
    int          wcnt = 0;
    int          data_lat = 0;
    logic        blk_en = 1'b0;
    logic [31:0] blk_addr = 32'd0;
    logic [31:0] prog [0:127];
    logic [31:0] mem  [0:127];
    logic        is_data;

    // Memory model: program image copied in during reset; data window 0x40..0x7F sees data_lat waits.
    assign is_data     = (mem_addr_o >= 32'h40) && (mem_addr_o < 32'h80);
    assign mem_ready_i = mem_req_o && !(blk_en && (mem_addr_o == blk_addr)) && (!is_data || (wcnt >= data_lat));
    assign mem_rdata_i = mem[mem_addr_o[8:2]];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset || !mem_req_o || mem_ready_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (reset) begin
            for (int i = 0; i < 128; i++) mem[i] <= prog[i];
        end else if (mem_req_o && mem_ready_i && mem_we_o) begin
            mem[mem_addr_o[8:2]] <= mem_wdata_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: request stability during waits, and every transfer against the queue.
    logic        pend = 1'b0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata;
    txn_t        e;
    always @(negedge clock) begin
        if (!reset && mem_req_o) begin
            if (pend) begin
                chk("hold_we", {31'd0, mem_we_o}, {31'd0, p_we});
                chk("hold_addr", mem_addr_o, p_addr);
                chk("hold_wdata", mem_wdata_o, p_wdata);
            end
            if (mem_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_txn: got we=%0b addr=%h, expected no transfer", mem_we_o, mem_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_we", {31'd0, mem_we_o}, {31'd0, e.we});
                    chk("txn_addr", mem_addr_o, e.addr);
                    if (e.we) chk("txn_wdata", mem_wdata_o, e.wdata);
                    if (e.dly >= 0) chk("txn_cycles", cyc - last_hs, e.dly);
                end
                last_hs = cyc;
                pend    = 1'b0;
            end else begin
                pend    = 1'b1;
                p_we    = mem_we_o;
                p_addr  = mem_addr_o;
                p_wdata = mem_wdata_o;
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic exp_rd(input logic [31:0] addr, input int dly);
        txn_t t;
        t.we = 1'b0; t.addr = addr; t.wdata = 32'd0; t.dly = dly;
        exp_q.push_back(t);
    endtask

    task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data, input int dly);
        txn_t t;
        t.we = 1'b1; t.addr = addr; t.wdata = data; t.dly = dly;
        exp_q.push_back(t);
    endtask

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    localparam logic [31:0] ECALL = 32'h0000_0073;

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) prog[i] = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted_o && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_halted"}, {31'd0, halted_o}, 32'd1);
    endtask

    task automatic end_test(input string name, input logic trap, input logic [31:0] ir, input logic [31:0] pc);
        chk({name, "_trap"}, {31'd0, trap_o}, {31'd0, trap});
        chk({name, "_instret"}, instret_o, ir);
        chk({name, "_pc"}, pc_o, pc);
        repeat (6) @(negedge clock);
        chk({name, "_req_idle"}, {31'd0, mem_req_o}, 32'd0);
        chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    logic [31:0] alu_exp [0:5];
    logic [4:0]  sw_reg  [0:5];

    initial begin
        reset = 1'b1;

        // ADDI/ADD/ECALL, zero-wait: 4 + 4 cycles between fetches, plus reset values
        clear_prog();
        prog[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = r_t(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);
        prog[2] = ECALL;
        exp_rd(32'h00, -1); exp_rd(32'h04, 4); exp_rd(32'h08, 4);
        do_reset();
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_halted", {31'd0, halted_o}, 32'd0);
        chk("rst_trap", {31'd0, trap_o}, 32'd0);
        chk("rst_instret", instret_o, 32'd0);
        wait_halt("t1");
        end_test("t1", 1'b0, 32'd2, 32'h08);

        // SW / LW round trip with 3 wait cycles on every data access
        clear_prog();
        prog[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = r_t(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);
        prog[2] = s_t(12'h040, 5'd2, 5'd0);
        prog[3] = i_t(12'h040, 5'd0, 3'b010, 5'd3, 7'b0000011);
        prog[4] = s_t(12'h044, 5'd3, 5'd0);
        prog[5] = ECALL;
        data_lat = 3;
        exp_rd(32'h00, -1); exp_rd(32'h04, 4); exp_rd(32'h08, 4);
        exp_wr(32'h40, 32'd10, 6); exp_rd(32'h0C, 1);
        exp_rd(32'h40, 6); exp_rd(32'h10, 2);
        exp_wr(32'h44, 32'd10, 6); exp_rd(32'h14, 1);
        do_reset();
        wait_halt("t2");
        end_test("t2", 1'b0, 32'd5, 32'h14);
        data_lat = 0;

        // ALU ops incl. negative operands, signed SLT both ways, write to x0 discarded
        alu_exp[0] = 32'd8; alu_exp[1] = 32'd5; alu_exp[2] = 32'hFFFF_FFFD;
        alu_exp[3] = 32'd1; alu_exp[4] = 32'd0; alu_exp[5] = 32'd0;
        sw_reg[0] = 5'd3; sw_reg[1] = 5'd4; sw_reg[2] = 5'd5;
        sw_reg[3] = 5'd6; sw_reg[4] = 5'd7; sw_reg[5] = 5'd0;
        clear_prog();
        prog[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = i_t(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
        prog[2] = r_t(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
        prog[3] = r_t(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd4);
        prog[4] = r_t(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd5);
        prog[5] = r_t(7'b0000000, 5'd1, 5'd2, 3'b010, 5'd6);
        prog[6] = r_t(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd7);
        prog[7] = r_t(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd0);
        for (int k = 0; k < 6; k++) prog[8+k] = s_t(12'h040 + 12'(4*k), sw_reg[k], 5'd0);
        prog[14] = ECALL;
        for (int a = 0; a <= 32'h20; a += 4) exp_rd(32'(a), (a == 0) ? -1 : 4);
        for (int k = 0; k < 6; k++) begin
            exp_wr(32'h40 + 32'(4*k), alu_exp[k], 3);
            exp_rd(32'h24 + 32'(4*k), 1);
        end
        do_reset();
        wait_halt("alu");
        end_test("alu", 1'b0, 32'd14, 32'h38);

        // BEQ taken backwards from 0x10 to 0x08
        clear_prog();
        prog[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = j_t(21'h0000C, 5'd0);
        prog[4] = b_t(13'h1FF8, 5'd1, 5'd1, 3'b000);
        prog[2] = ECALL;
        exp_rd(32'h00, -1); exp_rd(32'h04, 4); exp_rd(32'h10, 3); exp_rd(32'h08, 3);
        do_reset();
        wait_halt("beq");
        end_test("beq", 1'b0, 32'd3, 32'h08);

        // BNE not taken falls through to 0x14
        clear_prog();
        prog[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = j_t(21'h0000C, 5'd0);
        prog[4] = b_t(13'h1FF8, 5'd1, 5'd1, 3'b001);
        prog[5] = ECALL;
        exp_rd(32'h00, -1); exp_rd(32'h04, 4); exp_rd(32'h10, 3); exp_rd(32'h14, 3);
        do_reset();
        wait_halt("bne");
        end_test("bne", 1'b0, 32'd3, 32'h14);

        // JAL x1,+0x100 at 0x20: link 0x24 observed through a store
        clear_prog();
        prog[0]  = j_t(21'h00020, 5'd0);
        prog[8]  = j_t(21'h00100, 5'd1);
        prog[72] = s_t(12'h040, 5'd1, 5'd0);
        prog[73] = ECALL;
        exp_rd(32'h00, -1); exp_rd(32'h20, 3); exp_rd(32'h120, 3);
        exp_wr(32'h40, 32'h24, 3); exp_rd(32'h124, 1);
        do_reset();
        wait_halt("jal");
        end_test("jal", 1'b0, 32'd3, 32'h124);

        // Illegal opcode 0x7F traps without retiring
        clear_prog();
        prog[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = 32'h0000_007F;
        exp_rd(32'h00, -1); exp_rd(32'h04, 4);
        do_reset();
        wait_halt("illegal");
        end_test("illegal", 1'b1, 32'd1, 32'h04);

        // Misaligned LW from 0x42 traps with no data request
        clear_prog();
        prog[0] = i_t(12'h042, 5'd0, 3'b010, 5'd3, 7'b0000011);
        exp_rd(32'h00, -1);
        do_reset();
        wait_halt("misalign");
        end_test("misalign", 1'b1, 32'd0, 32'h00);

        // Reset while the fetch at 0x04 is stalled; execution then restarts cleanly
        clear_prog();
        prog[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = r_t(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);
        prog[2] = ECALL;
        blk_en = 1'b1;
        blk_addr = 32'h04;
        exp_rd(32'h00, -1);
        do_reset();
        begin
            int n = 0;
            while (!(mem_req_o && mem_addr_o == 32'h04) && n < 50) begin
                @(negedge clock);
                n++;
            end
        end
        chk("stall_req", {31'd0, mem_req_o}, 32'd1);
        repeat (3) @(negedge clock);
        chk("stall_instret", instret_o, 32'd1);
        chk("stall_pc", pc_o, 32'h04);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        blk_en = 1'b0;
        chk("abort_req", {31'd0, mem_req_o}, 32'd0);
        chk("abort_pc", pc_o, 32'd0);
        chk("abort_instret", instret_o, 32'd0);
        chk("abort_queue", exp_q.size(), 32'd0);
        exp_rd(32'h00, -1); exp_rd(32'h04, 4); exp_rd(32'h08, 4);
        wait_halt("restart");
        end_test("restart", 1'b0, 32'd2, 32'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_multicycle.md
# core_multicycle

Multi-cycle RV32I-subset core, successor to the single-cycle `core`. Fetches and executes over a single shared memory port with a valid/ready handshake, so instruction and data memory can have any latency. Integer datapath state lives in the existing `register_file` and `ula` blocks, sequenced by an explicit FSM. Adds halt/trap reporting and a retired-instruction counter.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `ADDR_W`, default 32: memory address width; PC is 32 bits and `mem_addr_o` is `pc[ADDR_W-1:0]` or the ALU result truncated to `ADDR_W`.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `mem_req_o`  out  1  memory request valid.
- `mem_we_o`  out  1  1 = word store, 0 = word read.
- `mem_addr_o`  out  ADDR_W  byte address, word aligned.
- `mem_wdata_o`  out  32  store data (rs2).
- `mem_ready_i`  in  1  memory accepts/completes the request this cycle.
- `mem_rdata_i`  in  32  read data, valid in the cycle `mem_req_o && mem_ready_i && !mem_we_o`.
- `pc_o`  out  32  current instruction PC.
- `halted_o`  out  1  core stopped (ECALL or trap).
- `trap_o`  out  1  halt cause was an illegal opcode or a misaligned access.
- `instret_o`  out  32  retired-instruction count.

## Operation
- Supported: R-type ADD/SUB/AND/OR/SLT (0110011), ADDI (0010011), LW (0000011), SW (0100011), BEQ/BNE (1100011), JAL (1101111), ECALL (1110011). Any other opcode is illegal.
- FSM states: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH: request `pc`, read. On handshake, latch the instruction into IR and go to DECODE.
- DECODE: read rs1/rs2 and build the immediate per the RV32I I/S/B/J formats. The B/J immediate is a byte offset with bit 0 = 0; no extra shift is applied. Illegal opcode goes to HALT with `trap_o` = 1. ECALL goes to HALT with `trap_o` = 0. Otherwise go to EXECUTE.
- EXECUTE:
  - R-type and ADDI: ALU result goes to WRITEBACK.
  - LW/SW: address = rs1 + imm. If `addr[1:0]` != 0, go to HALT with `trap_o` = 1. Otherwise go to MEM.
  - BEQ/BNE: `pc` ← `pc` + imm if the condition holds, else `pc` + 4. Retire, then go to FETCH.
  - JAL: rd ← `pc` + 4 and `pc` ← `pc` + imm in the same cycle. Retire, then go to FETCH.
- MEM: hold request until handshake. LW goes to WRITEBACK with the latched `mem_rdata_i`. SW retires, `pc` += 4, then goes to FETCH.
- WRITEBACK: write rd (writes to x0 discarded), `pc` += 4, retire, go to FETCH.
- HALT is terminal until reset. `mem_req_o` = 0 and `instret_o` is frozen.
- Retire means `instret_o` += 1, wrapping modulo 2^32. ECALL and trapped instructions do not retire.
- Arithmetic is 32-bit and wraps. SLT is signed. PC arithmetic wraps at 2^32.

## Timing
- Reset values: `mem_req_o` 0, `mem_we_o` 0, `mem_addr_o` 0, `mem_wdata_o` 0, `pc_o` `RESET_PC`, `halted_o` 0, `trap_o` 0, `instret_o` 0. FSM resets to FETCH.
- The first fetch request is asserted in the first cycle after `reset` is deasserted.
- Handshake:
  - `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are held stable from request assertion until the handshake cycle.
  - A transfer happens only in a cycle with `mem_req_o` and `mem_ready_i` both high.
  - `mem_req_o` deasserts in the cycle after the handshake, and never goes high outside FETCH/MEM.
  - `mem_ready_i` while `mem_req_o` = 0 is ignored.
- Cycle counts with zero-wait memory (ready high whenever req is high), measured from one fetch request to the next:
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ/BNE, JAL: 3 cycles.
  - Each wait cycle (req high, ready low) adds one cycle.
- `pc_o` changes only at retire. `instret_o` updates in the same cycle as the retire.
- `reset` during an outstanding request aborts it: `mem_req_o` is 0 the cycle after reset is sampled, and no register or memory side effect completes.

## Structure
- Package `core_mc_pkg`: FSM state enum, opcode/funct3/funct7 constants, ALU select encoding shared with `ula_control`, and the immediate-format decode function.
- Reuses `register_file` (x0 reads as 0) and `ula`.
- One natural new sub-module, `core_mc_decode`: combinational IR → control bundle (ALU select, immediate, instruction class, illegal flag).

## Test plan
- ADDI x1,x0,5 then ADD x2,x1,x1 then ECALL, zero-wait memory → x2 = 10, `instret_o` = 2, `halted_o` = 1, `trap_o` = 0, 8 cycles from first request to the ECALL fetch.
- SW x2,0x40(x0) then LW x3,0x40(x0), with `mem_ready_i` low for 3 cycles on each data access → store data 10 at address 0x40, x3 = 10, request signals held stable during the waits.
- BEQ x1,x1,-8 at PC 0x10 → next fetch at 0x08. BNE x1,x1,-8 at PC 0x10 → next fetch at 0x14.
- JAL x1,+0x100 at PC 0x20 → x1 = 0x24, next fetch at 0x120. Opcode 0x7F → `halted_o` = 1, `trap_o` = 1, `instret_o` unchanged.
- LW from address 0x42 → `trap_o` = 1 with no data-memory request issued. Reset asserted mid-fetch with `mem_ready_i` low → `pc_o` = `RESET_PC`, `instret_o` = 0, fetch restarts at `RESET_PC`.
